// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch requester, load/store requester and unified-memory
//   signals that connect to mem_port_arbiter.
//   slave  : arbiter side (takes requests and read data, drives grants,
//            responses and the memory control/address/data lines)
//   master : requester/memory side (the core stages and the memory model)
//   Fetch   : if_req, if_addr -> if_gnt, if_rvalid, if_rdata, if_err
//   LSU     : d_req, d_we, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata, d_err
//   Memory  : mem_en, rd_wr, mem_read_addr, mem_write_addr, mem_write_data,
//             mem_read_data (combinational from mem_read_addr)
interface mem_port_arbiter_if #(
  parameter int data_width = 32,
  parameter int addr_width = 32
);
  logic                  if_req;
  logic [addr_width-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [data_width-1:0] if_rdata;
  logic                  if_err;

  logic                  d_req;
  logic                  d_we;
  logic [addr_width-1:0] d_addr;
  logic [data_width-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [data_width-1:0] d_rdata;
  logic                  d_err;

  logic                  mem_en;
  logic                  rd_wr;
  logic [addr_width-1:0] mem_read_addr;
  logic [addr_width-1:0] mem_write_addr;
  logic [data_width-1:0] mem_write_data;
  logic [data_width-1:0] mem_read_data;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_read_data,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_en, rd_wr, mem_read_addr, mem_write_addr, mem_write_data
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_read_data,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_en, rd_wr, mem_read_addr, mem_write_addr, mem_write_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, byte-addressed memory between the fetch port
//   (read-only) and the load/store port (read/write). A two-state sequencer
//   (IDLE -> ACCESS -> IDLE) launches one access every two cycles; all memory
//   lines and responses come from registers. Misaligned or out-of-range word
//   addresses are rejected with err=1, rdata=0 and no memory enable.
//   Ports:
//     clk  : clock, all state updates on posedge
//     rst  : asynchronous active-low reset
//     bus  : mem_port_arbiter_if.slave (requests, responses, memory lines)
//   Build option:
//     MEM_PORT_ARB_RR_EN defined   -> round-robin between the two ports
//     MEM_PORT_ARB_RR_EN undefined -> load/store port always wins contention
module mem_port_arbiter #(
  parameter int data_width = 32,
  parameter int addr_width = 32,
  parameter int mem_bytes  = 16384
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [addr_width-1:0] LP_MAX_ADDR = addr_width'(mem_bytes - 4);

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                  w_grant;
  logic                  w_grant_d;
  logic                  w_complete;
  logic                  w_pick_d;
  logic                  w_legal;
  logic [addr_width-1:0] w_req_addr;
  logic [data_width-1:0] w_rsp_data;

  logic                  r_sel_d;
  logic                  r_we;
  logic                  r_legal;
  logic [addr_width-1:0] r_addr;
  logic [data_width-1:0] r_wdata;
  logic                  r_mem_en;
  logic                  r_rd_wr;

  logic                  r_if_gnt;
  logic                  r_if_rvalid;
  logic [data_width-1:0] r_if_rdata;
  logic                  r_if_err;
  logic                  r_d_gnt;
  logic                  r_d_rvalid;
  logic [data_width-1:0] r_d_rdata;
  logic                  r_d_err;

`ifdef MEM_PORT_ARB_RR_EN
  // Last-granted pointer: 1 = load/store, 0 = fetch.
  logic r_last_d;
  assign w_pick_d = bus.d_req & (~bus.if_req | ~r_last_d);
`else
  assign w_pick_d = bus.d_req;
`endif

  assign w_req_addr = w_pick_d ? bus.d_addr : bus.if_addr;
  assign w_legal    = (w_req_addr[1:0] == 2'b00) && (w_req_addr <= LP_MAX_ADDR);

  // Stores and rejected accesses return zero data.
  assign w_rsp_data = (r_legal && !r_we) ? bus.mem_read_data : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_d   = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.if_req || bus.d_req) begin
          w_grant     = 1'b1;
          w_grant_d   = w_pick_d;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_complete  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel_d     <= 1'b1;
      r_we        <= 1'b0;
      r_legal     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mem_en    <= 1'b0;
      r_rd_wr     <= 1'b1;
      r_if_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_if_err    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= '0;
      r_d_err     <= 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
      r_last_d    <= 1'b1;
`endif
    end else begin
      r_if_gnt    <= w_grant & ~w_grant_d;
      r_d_gnt     <= w_grant &  w_grant_d;
      r_if_rvalid <= w_complete & ~r_sel_d;
      r_d_rvalid  <= w_complete &  r_sel_d;
      // Enable is only ever high for the single ACCESS cycle of a legal request.
      r_mem_en    <= w_grant & w_legal;

      if (w_grant) begin
        r_sel_d <= w_grant_d;
        r_addr  <= w_req_addr;
        r_we    <= w_grant_d & bus.d_we;
        r_wdata <= w_grant_d ? bus.d_wdata : '0;
        r_legal <= w_legal;
        r_rd_wr <= ~(w_grant_d & bus.d_we);
`ifdef MEM_PORT_ARB_RR_EN
        r_last_d <= w_grant_d;
`endif
      end

      if (w_complete) begin
        if (r_sel_d) begin
          r_d_rdata <= w_rsp_data;
          r_d_err   <= ~r_legal;
        end else begin
          r_if_rdata <= w_rsp_data;
          r_if_err   <= ~r_legal;
        end
      end
    end
  end

  assign bus.if_gnt         = r_if_gnt;
  assign bus.if_rvalid      = r_if_rvalid;
  assign bus.if_rdata       = r_if_rdata;
  assign bus.if_err         = r_if_err;
  assign bus.d_gnt          = r_d_gnt;
  assign bus.d_rvalid       = r_d_rvalid;
  assign bus.d_rdata        = r_d_rdata;
  assign bus.d_err          = r_d_err;
  assign bus.mem_en         = r_mem_en;
  assign bus.rd_wr          = r_rd_wr;
  assign bus.mem_read_addr  = r_addr;
  assign bus.mem_write_addr = r_addr;
  assign bus.mem_write_data = r_wdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter and sequencer for the single-ported, byte-addressed unified memory. It shares one memory instance between the instruction-fetch port (read-only) and the load/store port (read/write). It serialises accesses through a two-state sequencer, drives the memory's `mem_en`/`rd_wr`/address/data lines from registered request fields, and returns registered responses with an error flag for illegal addresses. It sits between the core's fetch/LSU stages and the memory.

## Interface
- `data_width`, 32: word width of requests, responses and the memory port.
- `addr_width`, 32: byte address width.
- `mem_bytes`, 16384: memory size in bytes. Legal word addresses are 0 .. `mem_bytes`-4.
- `clk` input 1: clock. All state updates on posedge.
- `rst` input 1: reset. Asynchronous, active-low.
- `if_req` input 1: fetch request. Held with `if_addr` stable until `if_gnt`.
- `if_addr` input `addr_width`: fetch byte address.
- `if_gnt` output 1: one-cycle pulse when the fetch access is launched.
- `if_rvalid` output 1: one-cycle pulse when the fetch response is valid.
- `if_rdata` output `data_width`: fetch read data. Valid with `if_rvalid`.
- `if_err` output 1: the fetch was rejected. Valid with `if_rvalid`.
- `d_req` input 1: load/store request. Held with its fields stable until `d_gnt`.
- `d_we` input 1: 1 = store, 0 = load.
- `d_addr` input `addr_width`: load/store byte address.
- `d_wdata` input `data_width`: store data.
- `d_gnt` output 1: one-cycle launch pulse for the load/store port.
- `d_rvalid` output 1: one-cycle response pulse for the load/store port.
- `d_rdata` output `data_width`: load data. 0 for stores.
- `d_err` output 1: the load/store was rejected. Valid with `d_rvalid`.
- `mem_en` output 1: memory enable.
- `rd_wr` output 1: 1 = read, 0 = write.
- `mem_read_addr` output `addr_width`: memory read address.
- `mem_write_addr` output `addr_width`: memory write address.
- `mem_write_data` output `data_width`: memory write data.
- `mem_read_data` input `data_width`: memory read data. Combinational from `mem_read_addr`.

## Operation
- States: IDLE, ACCESS. Reset state is IDLE.
- **IDLE**
  - No requester active: stay in IDLE.
  - One or more requesters active: pick a winner per the arbitration rule and latch its addr/we/wdata into the request registers. Evaluate legality: `addr[1:0]==0` and `addr <= mem_bytes-4`. Register the winner's `gnt` high. Go to ACCESS.
- **ACCESS**
  - `gnt` for the winner is high during this cycle only.
  - Legal request: `mem_en=1`. `rd_wr` = ~we, or 1 for fetch. Both memory address outputs = latched addr. `mem_write_data` = latched wdata.
  - Illegal request: `mem_en=0`. The memory is not touched.
  - At the cycle end, register the winner's `rvalid`=1, `rdata`, and `err`, then return to IDLE.
  - `rdata` = `mem_read_data` for legal reads. It is 0 for stores and for errors.
- `rdata` and `err` hold their value until that port's next response.
- A requester may drop `req` in the cycle after `gnt`. A requester that keeps `req` high in IDLE is treated as a new request with the fields presented in that cycle.
- Fixed priority when the macro below is absent: the load/store port wins all contention.
- `mem_en` is 0 in IDLE. Outputs to the memory are driven only from registers, never from requester inputs.

## Timing
- Reset (asynchronous assert): `mem_en`=0, `rd_wr`=1, memory address and data outputs=0, all `gnt`/`rvalid`/`err`=0, all `rdata`=0, state=IDLE, RR pointer=load/store.
- Reset mid-ACCESS: `mem_en` drops immediately. The in-flight request produces no `gnt` completion or `rvalid`. Requesters re-issue after release.
- Request seen in IDLE at cycle N: `gnt` and the memory access occur in N+1, and `rvalid` occurs in N+2. The cycle N+2 is IDLE again and arbitrates.
- Latency is 2 cycles from `req` to `rvalid`. Peak throughput is 1 access per 2 cycles.
- A store write commits at the posedge ending cycle N+1. A load issued at N+2 observes the stored data.
- Simultaneous `if_req` and `d_req`: exactly one `gnt` is issued. The loser stays pending and is granted in the next IDLE cycle unless it is outbid again.

## Configuration
- `MEM_PORT_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit last-granted pointer is updated on every grant.
  - On contention, the port that was not last granted wins.
  - The pointer resets to load/store, so the first contention goes to fetch.
- `MEM_PORT_ARB_RR_EN` undefined: no pointer; fixed load/store-first priority. Fetch can starve under continuous load/store traffic.

## Test plan
- **Store then load.** d store addr 0x10, wdata 0xDEADBEEF. Then d load addr 0x10.
  - Required: `d_gnt` at N+1 with `mem_en`=1 and `rd_wr`=0. `d_rvalid` at N+2 with `d_err`=0.
  - Required: the load returns `d_rdata`=0xDEADBEEF, 2 cycles after its `req`.
- **Fetch read.** Preload 0x00000013 at addr 0x0. Fetch addr 0x0.
  - Required: `if_rvalid` at N+2, `if_rdata`=0x00000013, `if_err`=0, `rd_wr`=1 during ACCESS.
- **Illegal addresses.** d load addr 0x12 (misaligned), then fetch addr 0x3FFE (`mem_bytes`-2).
  - Required: each gets `rvalid` with `err`=1 and `rdata`=0. `mem_en` stays 0 throughout.
- **Contention.** `if_req` and `d_req` both high and held.
  - Macro undefined: grants go d, d, d… and fetch is never granted while `d_req` stays high.
  - Macro defined: grants go if, d, if, d, one grant every 2 cycles.
- **Reset mid-access.** Assert `rst`=0 during the ACCESS cycle of a store to 0x20.
  - Required: `mem_en` goes to 0 immediately. No `d_rvalid`. All outputs hold reset values until release.
  - Required: after release with `d_req` still high, the store completes normally.
